cache_line_mover: RTL and testbench

//  Line-transfer sequencer between the direct-mapped cache controller and the four-bank main memory.
//  On command it performs a 4-word writeback of a dirty victim line and/or a 4-word fill of the missing line.
//  It issues word accesses to the memory, steers returning data into the cache data array, and reports busy/done/err.
//  The controller holds its stall while busy is high.

---
 rtl/cache_line_mover_if.sv | 44 ++++
 rtl/cache_line_mover.sv | 173 +++++++++++++++++
 tb/tb_cache_line_mover.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_mover_if.sv
// Handshake and data bundle between the cache controller/memory and the line mover.
// The mover uses the slave modport; the controller/memory side uses master.
interface cache_line_mover_if #(
    parameter int TAG_W  = 5,
    parameter int IDX_W  = 8,
    parameter int WORD_W = 16
);
    logic              start_wb;
    logic              start_fill;
    logic [TAG_W-1:0]  tag_old;
    logic [TAG_W-1:0]  tag_new;
    logic [IDX_W-1:0]  index;
    logic [1:0]        req_offset;
    logic [1:0]        cache_offset;
    logic              cache_rd;
    logic [WORD_W-1:0] cache_data_in;
    logic              cache_wr;
    logic [WORD_W-1:0] cache_data_out;
    logic [15:0]       mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [WORD_W-1:0] mem_data_out;
    logic [WORD_W-1:0] mem_data_in;
    logic              mem_stall;
    logic [3:0]        mem_busy;
    logic              mem_err;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start_wb, start_fill, tag_old, tag_new, index, req_offset,
        input  cache_data_in, mem_data_in, mem_stall, mem_busy, mem_err,
        output cache_offset, cache_rd, cache_wr, cache_data_out,
        output mem_addr, mem_rd, mem_wr, mem_data_out, busy, done, err
    );

    modport master (
        output start_wb, start_fill, tag_old, tag_new, index, req_offset,
        output cache_data_in, mem_data_in, mem_stall, mem_busy, mem_err,
        input  cache_offset, cache_rd, cache_wr, cache_data_out,
        input  mem_addr, mem_rd, mem_wr, mem_data_out, busy, done, err
    );
endinterface

// File: rtl/cache_line_mover.sv
// Writeback/fill line sequencer between the direct-mapped cache and banked main memory.
// Optional CRITICAL_WORD_FIRST_EN: fill starts at the requested word and wraps mod 4.
module cache_line_mover #(
    parameter int TAG_W  = 5,
    parameter int IDX_W  = 8,
    parameter int WORD_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    cache_line_mover_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, WB, FILL_ISSUE, FILL_DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic              fill_pend_q;
    logic [1:0]        word_q;
    logic [2:0]        issued_q;
    logic [2:0]        wr_cnt_q;
    logic              err_q;
    logic [TAG_W-1:0]  tag_old_q;
    logic [TAG_W-1:0]  tag_new_q;
    logic [IDX_W-1:0]  index_q;
    logic [RD_LAT-1:0] rd_vld_p;
    logic [1:0]        rd_off_p [RD_LAT];

    logic       start_any;
    logic       can_issue;
    logic       wb_issue;
    logic       rd_issue;
    logic       fill_wr;
    logic [1:0] fill_off_now;
    logic [1:0] fill_off_lat;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [1:0] req_off_q;

    always_ff @(posedge clk) begin
        if (state == IDLE && start_any)
            req_off_q <= bus.req_offset;
    end

    assign fill_off_now = bus.req_offset;
    assign fill_off_lat = req_off_q;
`else
    logic unused_req_offset;

    assign unused_req_offset = ^bus.req_offset;
    assign fill_off_now      = 2'd0;
    assign fill_off_lat      = 2'd0;
`endif

    assign start_any = bus.start_wb || bus.start_fill;
    assign can_issue = !bus.mem_stall && !bus.mem_busy[word_q] && !issued_q[2];
    assign wb_issue  = (state == WB) && can_issue;
    assign rd_issue  = (state == FILL_ISSUE) && can_issue;
    assign fill_wr   = rd_vld_p[RD_LAT-1];

    // Control state: async reset clears the FSM and the read-valid pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fill_pend_q <= 1'b0;
            word_q      <= 2'd0;
            issued_q    <= 3'd0;
            wr_cnt_q    <= 3'd0;
            err_q       <= 1'b0;
            rd_vld_p    <= '0;
        end else begin
            state       <= state_nxt;
            rd_vld_p[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++)
                rd_vld_p[i] <= rd_vld_p[i-1];

            if (state == IDLE && start_any) begin
                fill_pend_q <= bus.start_wb && bus.start_fill;
                word_q      <= bus.start_wb ? 2'd0 : fill_off_now;
                issued_q    <= 3'd0;
                wr_cnt_q    <= 3'd0;
            end

            if (wb_issue) begin
                if (issued_q == 3'd3) begin
                    word_q   <= fill_off_lat;
                    issued_q <= 3'd0;
                end else begin
                    word_q   <= word_q + 2'd1;
                    issued_q <= issued_q + 3'd1;
                end
            end

            if (rd_issue) begin
                word_q   <= word_q + 2'd1;
                issued_q <= issued_q + 3'd1;
            end

            if (fill_wr)
                wr_cnt_q <= wr_cnt_q + 3'd1;

            if (state == DONE)
                err_q <= 1'b0;
            else if (state != IDLE && bus.mem_err)
                err_q <= 1'b1;
        end
    end

    // Data capture: line address and the read-offset pipeline need no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && start_any) begin
            tag_old_q <= bus.tag_old;
            tag_new_q <= bus.tag_new;
            index_q   <= bus.index;
        end
        rd_off_p[0] <= word_q;
        for (int i = 1; i < RD_LAT; i++)
            rd_off_p[i] <= rd_off_p[i-1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_wb)
                    state_nxt = WB;
                else if (bus.start_fill)
                    state_nxt = FILL_ISSUE;
            end
            WB: begin
                if (wb_issue && issued_q == 3'd3)
                    state_nxt = fill_pend_q ? FILL_ISSUE : DONE;
            end
            FILL_ISSUE: begin
                if (rd_issue && issued_q == 3'd3)
                    state_nxt = FILL_DRAIN;
            end
            FILL_DRAIN: begin
                if (fill_wr && wr_cnt_q == 3'd3)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are zero unless an issue or fill write happens this cycle
    always_comb begin
        bus.cache_rd       = wb_issue;
        bus.cache_wr       = fill_wr;
        bus.cache_offset   = 2'd0;
        bus.cache_data_out = '0;
        bus.mem_rd         = rd_issue;
        bus.mem_wr         = wb_issue;
        bus.mem_addr       = 16'd0;
        bus.mem_data_out   = '0;
        bus.busy           = (state != IDLE);
        bus.done           = (state == DONE);
        bus.err            = (state == DONE) && err_q;

        if (wb_issue) begin
            bus.cache_offset = word_q;
            bus.mem_addr     = {tag_old_q, index_q, word_q, 1'b0};
            bus.mem_data_out = bus.cache_data_in;
        end else if (fill_wr) begin
            bus.cache_offset   = rd_off_p[RD_LAT-1];
            bus.cache_data_out = bus.mem_data_in;
        end

        if (rd_issue)
            bus.mem_addr = {tag_new_q, index_q, word_q, 1'b0};
    end

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed and randomized transfers against a queue-based model of the line mover.
module tb_cache_line_mover;
    localparam int TAG_W  = 5;
    localparam int IDX_W  = 8;
    localparam int WORD_W = 16;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_line_mover_if #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WORD_W(WORD_W)) bus ();

    cache_line_mover #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WORD_W(WORD_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {bit wr; logic [15:0] addr; logic [15:0] data;} op_t;
    typedef struct {int due; logic [1:0] off; logic [15:0] data;} rw_t;

    logic [WORD_W-1:0] cache_arr [4];
    logic [15:0]       rd_dat_at [512];
    bit                rd_vld_at [512];
    logic [15:0]       mem_seed;
    op_t               ops [$];
    rw_t               pend [$];
    int                checks = 0;
    int                errors = 0;

    assign bus.cache_data_in = cache_arr[bus.cache_offset];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'h9E37;
        return m ^ mem_seed ^ {a[7:0], a[15:8]};
    endfunction

    function automatic logic [1:0] first_fill_off(input logic [1:0] r);
`ifdef CRITICAL_WORD_FIRST_EN
        return r;
`else
        return 2'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input bit do_wb, input bit do_fill, input logic [4:0] told,
                            input logic [4:0] tnew, input logic [7:0] idx, input logic [1:0] roff,
                            input int stall_pct, input int busy_pct, input int busy_bank,
                            input int busy_from, input int busy_len, input int err_at,
                            input int abort_at, output int done_rel);
        op_t        o;
        rw_t        w;
        logic [3:0] bsy;
        logic [1:0] k;
        bit         stl, iss, ew, fin;
        int         done_due;

        foreach (cache_arr[i]) cache_arr[i] = 16'($urandom);
        mem_seed = 16'($urandom);
        ops.delete();
        pend.delete();
        foreach (rd_vld_at[i]) rd_vld_at[i] = 1'b0;
        if (do_wb)
            for (int i = 0; i < 4; i++) begin
                o.wr = 1'b1; o.addr = {told, idx, 2'(i), 1'b0}; o.data = cache_arr[i];
                ops.push_back(o);
            end
        if (do_fill)
            for (int i = 0; i < 4; i++) begin
                k = first_fill_off(roff) + 2'(i);
                o.wr = 1'b0; o.addr = {tnew, idx, k, 1'b0}; o.data = mem_word(o.addr);
                ops.push_back(o);
            end

        bus.start_wb = do_wb; bus.start_fill = do_fill;
        bus.tag_old = told; bus.tag_new = tnew; bus.index = idx; bus.req_offset = roff;
        bus.mem_stall = 1'b0; bus.mem_busy = 4'h0; bus.mem_err = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_issue", bus.mem_rd | bus.mem_wr, 0);
        @(posedge clk); #1;
        bus.start_wb = 1'b0; bus.start_fill = 1'b0;
        bus.tag_old = 5'($urandom); bus.tag_new = 5'($urandom);
        bus.index = 8'($urandom); bus.req_offset = 2'($urandom);

        done_due = -1; done_rel = -1; fin = 1'b0;
        for (int rel = 1; rel <= 300 && !fin; rel++) begin
            stl = ($urandom_range(99) < stall_pct);
            bsy = 4'h0;
            for (int b = 0; b < 4; b++) if ($urandom_range(99) < busy_pct) bsy[b] = 1'b1;
            if (busy_bank >= 0 && rel >= busy_from && rel < busy_from + busy_len) bsy[busy_bank] = 1'b1;
            bus.mem_stall = stl; bus.mem_busy = bsy; bus.mem_err = (rel == err_at);
            bus.mem_data_in = rd_vld_at[rel] ? rd_dat_at[rel] : 16'($urandom);
            if (rel == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", bus.busy, 0);
                chk("abort_cache_wr", bus.cache_wr, 0);
                chk("abort_mem_rd", bus.mem_rd, 0);
                chk("abort_done", bus.done, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                bus.mem_stall = 1'b0; bus.mem_busy = 4'h0; bus.mem_err = 1'b0;
                return;
            end
            @(negedge clk);
            chk("rd_wr_overlap", bus.mem_rd & bus.mem_wr, 0);
            iss = (ops.size() > 0) && !stl && !bsy[ops[0].addr[2:1]];
            chk("issue", bus.mem_rd | bus.mem_wr, iss);
            chk("cache_rd", bus.cache_rd, iss ? ops[0].wr : 1'b0);
            if (iss) begin
                o = ops.pop_front();
                chk("mem_wr_kind", bus.mem_wr, o.wr);
                chk("mem_addr", bus.mem_addr, o.addr);
                if (o.wr) begin
                    chk("mem_data_out", bus.mem_data_out, o.data);
                    chk("wb_offset", bus.cache_offset, o.addr[2:1]);
                    if (ops.size() == 0) done_due = rel + 1;
                end else begin
                    w.due = rel + RD_LAT; w.off = o.addr[2:1]; w.data = o.data;
                    pend.push_back(w);
                    rd_vld_at[w.due] = 1'b1; rd_dat_at[w.due] = o.data;
                end
            end
            ew = (pend.size() > 0) && (pend[0].due == rel);
            chk("cache_wr", bus.cache_wr, ew);
            if (ew) begin
                w = pend.pop_front();
                chk("fill_offset", bus.cache_offset, w.off);
                chk("fill_data", bus.cache_data_out, w.data);
                if (ops.size() == 0 && pend.size() == 0) done_due = rel + 1;
            end
            chk("busy", bus.busy, 1);
            chk("done", bus.done, rel == done_due);
            if (bus.done) begin
                chk("err", bus.err, err_at > 0);
                done_rel = rel;
                fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.mem_stall = 1'b0; bus.mem_busy = 4'h0; bus.mem_err = 1'b0;
        chk("done_seen", fin, 1);
        @(negedge clk);
        chk("back_idle", bus.busy, 0);
        chk("done_single", bus.done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int d;
        rst = 1'b1;
        bus.start_wb = 1'b0; bus.start_fill = 1'b0;
        bus.tag_old = '0; bus.tag_new = '0; bus.index = '0; bus.req_offset = 2'd0;
        bus.mem_data_in = '0; bus.mem_stall = 1'b0; bus.mem_busy = 4'h0; bus.mem_err = 1'b0;
        foreach (cache_arr[i]) cache_arr[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_cache_wr", bus.cache_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // fill only, no stalls
        run_xfer(0, 1, 5'h00, 5'h03, 8'h12, 2'd0, 0, 0, -1, 0, 0, -1, -1, d);
        chk("t1_done_cycle", d, 7);
        // writeback then fill
        run_xfer(1, 1, 5'h1F, 5'($urandom), 8'h00, 2'($urandom), 0, 0, -1, 0, 0, -1, -1, d);
        chk("t2_done_cycle", d, 11);
        // bank 2 busy for three cycles
        run_xfer(0, 1, 5'h00, 5'h0A, 8'h5C, 2'd0, 0, 0, 2, 3, 3, -1, -1, d);
        chk("t3_done_cycle", d, 10);
        // error during second writeback word, then clean transfer
        run_xfer(1, 0, 5'h11, 5'h00, 8'hA7, 2'd0, 0, 0, -1, 0, 0, 2, -1, d);
        run_xfer(1, 0, 5'h12, 5'h00, 8'hA8, 2'd0, 0, 0, -1, 0, 0, -1, -1, d);
        // reset while draining with a read in flight
        run_xfer(0, 1, 5'h00, 5'h07, 8'h33, 2'd0, 0, 0, -1, 0, 0, -1, 5, d);
        for (int i = 0; i < 2; i++) begin
            bus.mem_data_in = 16'($urandom);
            @(negedge clk);
            chk("post_rst_cache_wr", bus.cache_wr, 0);
            chk("post_rst_busy", bus.busy, 0);
            @(posedge clk); #1;
        end
        run_xfer(0, 1, 5'h00, 5'h07, 8'h33, 2'd0, 0, 0, -1, 0, 0, -1, -1, d);
        // requested word 2
        run_xfer(0, 1, 5'h00, 5'h15, 8'h44, 2'd2, 0, 0, -1, 0, 0, -1, -1, d);
        run_xfer(1, 1, 5'h09, 5'h15, 8'h45, 2'd3, 0, 0, -1, 0, 0, -1, -1, d);
        // randomized transfers with stalls, bank busy and errors
        for (int n = 0; n < 12; n++) begin
            bit wb, fl;
            int ea;
            wb = 1'($urandom_range(1));
            fl = wb ? 1'($urandom_range(1)) : 1'b1;
            ea = ($urandom_range(1) == 1) ? int'($urandom_range(4, 1)) : -1;
            run_xfer(wb, fl, 5'($urandom), 5'($urandom), 8'($urandom), 2'($urandom),
                     25, 10, -1, 0, 0, ea, -1, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
